uart_rx_frame_ctrl: RTL and testbench

- Frame controller that sequences the bit stream produced by uart_sampler.
- Consumes one `data_valid`/`data_bit` pulse per sampled UART bit, including the start and stop bits.
- Frames 8N1 bytes, checks the stop bit and enforces an inter-bit timeout.
- Compares each good byte against a target pattern and flags matches to the detector top level.

---
 rtl/uart_rx_frame_ctrl.sv | 121 ++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: frames 8N1 bytes from the sampler's per-bit strobes.
// It checks the stop bit, enforces an inter-bit timeout and flags bytes
// that equal PATTERN.
module uart_rx_frame_ctrl #(
  parameter int          CLK_FREQ     = 25_000_000,
  parameter int          BAUD_RATE    = 115200,
  parameter logic [7:0]  PATTERN      = 8'hA5,
  parameter int          TIMEOUT_BITS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       data_valid,
  input  logic       data_bit,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       match,
  output logic       frame_err,
  output logic       busy,
  output logic [7:0] match_count
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int TO_LIMIT     = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TO_W         = $clog2(TO_LIMIT + 1);
  // The error fires on the edge where the count would reach TO_LIMIT, so
  // TO_LIMIT strobe-less clocks after the last accepted bit.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_LIMIT - 1);

  typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;

  state_t            state;
  logic [7:0]        shreg;
  logic [2:0]        bit_idx;
  logic [TO_W-1:0]   to_cnt;

  // Frame sequencer: all outputs registered; pulses default low each cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      shreg       <= '0;
      bit_idx     <= '0;
      to_cnt      <= '0;
      byte_out    <= '0;
      byte_valid  <= 1'b0;
      match       <= 1'b0;
      frame_err   <= 1'b0;
      busy        <= 1'b0;
      match_count <= '0;
    end else begin
      byte_valid <= 1'b0;
      match      <= 1'b0;
      frame_err  <= 1'b0;
      if (!enable) begin
        // Disabled: drop any partial frame silently.
        state   <= IDLE;
        busy    <= 1'b0;
        shreg   <= '0;
        bit_idx <= '0;
        to_cnt  <= '0;
      end else begin
        case (state)
          IDLE: begin
            // A 1 here is idle line; only a 0 starts a frame.
            if (data_valid && !data_bit) begin
              state   <= DATA;
              busy    <= 1'b1;
              shreg   <= '0;
              bit_idx <= '0;
              to_cnt  <= '0;
            end
          end
          DATA: begin
            if (data_valid) begin
              shreg   <= {data_bit, shreg[7:1]};
              bit_idx <= bit_idx + 3'd1;
              to_cnt  <= '0;
              if (bit_idx == 3'd7) state <= STOP;
            end else if (to_cnt == TO_LAST) begin
              frame_err <= 1'b1;
              state     <= IDLE;
              busy      <= 1'b0;
              to_cnt    <= '0;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end
          STOP: begin
            if (data_valid) begin
              state  <= IDLE;
              busy   <= 1'b0;
              to_cnt <= '0;
              if (data_bit) begin
                byte_out   <= shreg;
                byte_valid <= 1'b1;
                if (shreg == PATTERN) begin
                  match <= 1'b1;
                  if (match_count != 8'hFF) match_count <= match_count + 8'd1;
                end
              end else begin
                frame_err <= 1'b1;
              end
            end else if (to_cnt == TO_LAST) begin
              frame_err <= 1'b1;
              state     <= IDLE;
              busy      <= 1'b0;
              to_cnt    <= '0;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl: frame-level reference model (expected byte,
// pulse counts, saturating match count) against a pulse monitor.
`timescale 1ns/1ps
module tb_uart_rx_frame_ctrl;

  localparam logic [7:0] PAT = 8'hA5;
  localparam int BIT_CLKS = 25_000_000 / 115200;   // 217
  localparam int TO_CLKS  = 2 * BIT_CLKS;          // 434

  logic       clk = 1'b0;
  logic       rst, enable, data_valid, data_bit;
  logic [7:0] byte_out, match_count;
  logic       byte_valid, match, frame_err, busy;

  uart_rx_frame_ctrl dut (
    .clk(clk), .rst(rst), .enable(enable), .data_valid(data_valid),
    .data_bit(data_bit), .byte_out(byte_out), .byte_valid(byte_valid),
    .match(match), .frame_err(frame_err), .busy(busy),
    .match_count(match_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  // Observed pulse counts and pulse-shape violations.
  int bv_cnt = 0, m_cnt = 0, fe_cnt = 0, wide = 0, orphan = 0;
  // Reference model state.
  int exp_bv = 0, exp_m = 0, exp_fe = 0, exp_cnt = 0;
  logic [7:0] exp_byte = 8'h00;
  logic prev_bv = 1'b0, prev_m = 1'b0, prev_fe = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulse monitor: counts pulses, flags pulses wider than one cycle and
  // matches without a coincident byte_valid.
  always @(negedge clk) begin
    if (byte_valid) bv_cnt++;
    if (match) m_cnt++;
    if (frame_err) fe_cnt++;
    if ((byte_valid && prev_bv) || (match && prev_m) || (frame_err && prev_fe)) wide++;
    if (match && !byte_valid) orphan++;
    prev_bv = byte_valid; prev_m = match; prev_fe = frame_err;
  end

  // One strobe sampled `gap` clocks after the previous sampled edge.
  task automatic strobe(input logic b, input int gap);
    repeat (gap - 1) @(negedge clk);
    data_valid = 1'b1; data_bit = b;
    @(negedge clk);
    data_valid = 1'b0; data_bit = 1'b0;
  endtask

  // Full frame plus model update: good stop -> byte, bad stop -> error.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int gap);
    strobe(1'b0, gap);
    for (int i = 0; i < 8; i++) strobe(d[i], gap);
    strobe(stop, gap);
    if (stop) begin
      exp_bv++; exp_byte = d;
      if (d == PAT) begin
        exp_m++;
        if (exp_cnt < 255) exp_cnt++;
      end
    end else begin
      exp_fe++;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".bv"}, bv_cnt, exp_bv);
    chk({tag, ".match"}, m_cnt, exp_m);
    chk({tag, ".ferr"}, fe_cnt, exp_fe);
    chk({tag, ".byte"}, {24'h0, byte_out}, {24'h0, exp_byte});
    chk({tag, ".mcnt"}, {24'h0, match_count}, exp_cnt);
    chk({tag, ".busy"}, {31'h0, busy}, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    int k, gap;
    rst = 1'b0; enable = 1'b1; data_valid = 1'b0; data_bit = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.byte", {24'h0, byte_out}, 0);
    chk("rst.flags", {28'h0, byte_valid, match, frame_err, busy}, 0);
    chk("rst.mcnt", {24'h0, match_count}, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // 1: pattern byte at line rate
    strobe(1'b0, BIT_CLKS);
    chk("t1.busy_mid", {31'h0, busy}, 1);
    for (int i = 0; i < 8; i++) strobe(PAT[i], BIT_CLKS);
    strobe(1'b1, BIT_CLKS);
    exp_bv++; exp_m++; exp_cnt++; exp_byte = PAT;
    chk("t1.bv_now", {31'h0, byte_valid}, 1);
    chk("t1.m_now", {31'h0, match}, 1);
    repeat (3) @(negedge clk);
    check_state("t1");

    // 2: non-matching byte
    send_frame(8'h3C, 1'b1, BIT_CLKS);
    check_state("t2");

    // 3: bad stop bit, then recovery
    send_frame(PAT, 1'b0, BIT_CLKS);
    check_state("t3");
    send_frame(8'h5A, 1'b1, 7);
    check_state("t3b");

    // 4: timeout after 4 data bits, exact cycle
    strobe(1'b0, 20);
    for (int i = 0; i < 4; i++) strobe(1'b1, BIT_CLKS);
    k = 0;
    for (int i = 1; i <= 600; i++) begin
      @(negedge clk);
      if (frame_err) begin k = i; break; end
    end
    exp_fe++;
    chk("t4.to_cycle", k, TO_CLKS);
    chk("t4.busy", {31'h0, busy}, 0);
    repeat (3) @(negedge clk);
    check_state("t4");
    // strobe landing exactly on the limit is accepted
    d = 8'hC3;
    strobe(1'b0, 20);
    for (int i = 0; i < 4; i++) strobe(d[i], BIT_CLKS);
    strobe(d[4], TO_CLKS);
    for (int i = 5; i < 8; i++) strobe(d[i], BIT_CLKS);
    strobe(1'b1, BIT_CLKS);
    exp_bv++; exp_byte = d;
    repeat (3) @(negedge clk);
    check_state("t4b");

    // 5: enable drop mid-frame
    strobe(1'b0, 20);
    for (int i = 0; i < 3; i++) strobe(1'b0, 20);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5.busy_dis", {31'h0, busy}, 0);
    strobe(1'b0, 5);
    repeat (2) @(negedge clk);
    chk("t5.busy_ign", {31'h0, busy}, 0);
    enable = 1'b1;
    repeat (5) @(negedge clk);
    check_state("t5");
    send_frame(PAT, 1'b1, 20);
    check_state("t5b");
    // async reset mid-frame
    strobe(1'b0, 20);
    for (int i = 0; i < 3; i++) strobe(1'b1, 20);
    #2 rst = 1'b0;
    #1;
    chk("t5.rst_byte", {24'h0, byte_out}, 0);
    chk("t5.rst_flags", {28'h0, byte_valid, match, frame_err, busy}, 0);
    chk("t5.rst_mcnt", {24'h0, match_count}, 0);
    exp_byte = 8'h00; exp_cnt = 0;
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    send_frame(PAT, 1'b1, 9);
    check_state("t5c");

    // random frames, random spacing incl. back-to-back strobes
    for (int n = 0; n < 24; n++) begin
      d = 8'($urandom);
      if (n % 6 == 0) d = PAT;
      gap = $urandom_range(4, 1);
      send_frame(d, ($urandom_range(3, 0) != 0), gap);
      check_state("rnd");
    end

    // 6: saturation with idle-line strobes between frames
    k = m_cnt;
    for (int n = 0; n < 260; n++) begin
      strobe(1'b1, 3);
      strobe(1'b1, 2);
      send_frame(PAT, 1'b1, $urandom_range(4, 2));
    end
    chk("t6.match_pulses", m_cnt - k, 260);
    chk("t6.mcnt", {24'h0, match_count}, 255);
    check_state("t6");
    chk("shape.wide", wide, 0);
    chk("shape.orphan", orphan, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
